dsp_mul_sequencer: RTL and testbench



---
 rtl/mul_pkg.sv | 43 ++++
 rtl/mac16_umul.sv | 35 +++
 rtl/dsp_mul_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_dsp_mul_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mul_pkg
//  Purpose  : Shared definitions for the sequenced 32x32 multiplier:
//             M-extension op encodings, FSM state encoding and the
//             per-step lane-select / shift schedule for the 16x16 DSP.
//  Revision : 1.0  initial release
// ============================================================================
package mul_pkg;

  // funct3[1:0] of the M-extension multiply group
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CORR  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bit n set: step n uses the upper 16 bits of that operand.
  // Step order: a_lo*b_lo, a_lo*b_hi, a_hi*b_lo, a_hi*b_hi.
  localparam logic [3:0] LANE_A_HI = 4'b1100;
  localparam logic [3:0] LANE_B_HI = 4'b1010;

  // Left shift applied to the partial product of step idx.
  function automatic logic [5:0] lane_shift(input logic [1:0] idx);
    logic [5:0] sh;
    case (idx)
      2'd0:    sh = 6'd0;
      2'd1:    sh = 6'd16;
      2'd2:    sh = 6'd16;
      default: sh = 6'd32;
    endcase
    return sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac16_umul.sv
`default_nettype none
// ============================================================================
//  Module   : mac16_umul
//  Purpose  : 16x16 unsigned multiply with a registered 32-bit product,
//             one cycle of latency. Behavioural stand-in for an iCE40
//             SB_MAC16 configured as an unsigned 16x16 multiplier with its
//             output register enabled.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous active-high reset (clears the product)
//             a, b  - 16-bit unsigned multiplicands
//             p     - registered 32-bit product of the previous cycle
//  Revision : 1.0  initial release
// ============================================================================
module mac16_umul (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] r_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= 32'd0;
    end else begin
      r_p <= {16'd0, a} * {16'd0, b};
    end
  end

  assign p = r_p;

endmodule
`default_nettype wire

// File: rtl/dsp_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mul_sequencer
//  Purpose  : Multi-cycle 32x32 multiplier for MUL/MULH/MULHSU/MULHU. Issues
//             four unsigned 16x16 partial products to one registered DSP
//             multiplier, accumulates the 64-bit unsigned product, applies
//             the signed correction and returns the selected 32-bit half.
//  Ports    : clk, reset            - clock / synchronous active-high reset
//             in_valid, in_ready    - operand handshake (ready only in IDLE)
//             op, op_a, op_b        - funct3[1:0], rs1, rs2
//             out_valid, out_ready  - result handshake
//             result                - product[31:0] for MUL, else [63:32]
//             busy                  - high whenever not IDLE
//  Revision : 1.0  initial release
// ============================================================================
module dsp_mul_sequencer
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next;

  logic [1:0]  r_idx;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_result;

  // Tag travelling one cycle behind the multiplier input, so the product
  // that appears at the DSP output is shifted by the step that produced it.
  logic        r_tag_vld;
  logic [1:0]  r_tag_idx;

  logic [15:0] w_lane_a;
  logic [15:0] w_lane_b;
  logic [31:0] w_prod;
  logic [63:0] w_shifted;
  logic        w_a_signed;
  logic        w_b_signed;
  logic [63:0] w_corr_a;
  logic [63:0] w_corr_b;
  logic [63:0] w_corrected;

  // --------------------------------------------------------------------------
  // Lane select and DSP
  // --------------------------------------------------------------------------
  assign w_lane_a = LANE_A_HI[r_idx] ? r_a[31:16] : r_a[15:0];
  assign w_lane_b = LANE_B_HI[r_idx] ? r_b[31:16] : r_b[15:0];

  mac16_umul u_mac (
    .clk   (clk),
    .reset (reset),
    .a     (w_lane_a),
    .b     (w_lane_b),
    .p     (w_prod)
  );

  assign w_shifted = {32'd0, w_prod} << lane_shift(r_tag_idx);

  // --------------------------------------------------------------------------
  // Signed correction: the unsigned product of a signed operand x with
  // x[31]=1 over-counts by 2^32 * other_operand, so subtract it back.
  // MUL needs none because the low half does not depend on signedness.
  // --------------------------------------------------------------------------
  assign w_a_signed  = (r_op == OP_MULH) || (r_op == OP_MULHSU);
  assign w_b_signed  = (r_op == OP_MULH);
  assign w_corr_a    = (w_a_signed && r_a[31]) ? {r_b, 32'd0} : 64'd0;
  assign w_corr_b    = (w_b_signed && r_b[31]) ? {r_a, 32'd0} : 64'd0;
  assign w_corrected = r_acc - w_corr_a - w_corr_b;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_idx == 2'd3) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_next = ST_CORR;
      end
      ST_CORR: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand capture and step counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_op  <= OP_MUL;
      r_idx <= 2'd0;
    end else begin
      if (r_state == ST_IDLE && in_valid) begin
        r_a   <= op_a;
        r_b   <= op_b;
        r_op  <= op;
        r_idx <= 2'd0;
      end else if (r_state == ST_ISSUE) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_vld <= 1'b0;
      r_tag_idx <= 2'd0;
    end else begin
      r_tag_vld <= (r_state == ST_ISSUE);
      r_tag_idx <= r_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator and result register. The tag is never valid in IDLE or
  // CORR, so clear, accumulate and correct cannot collide.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= 64'd0;
      r_result <= 32'd0;
    end else begin
      if (r_state == ST_IDLE && in_valid) begin
        r_acc <= 64'd0;
      end else if (r_tag_vld) begin
        r_acc <= r_acc + w_shifted;
      end else if (r_state == ST_CORR) begin
        r_acc    <= w_corrected;
        r_result <= (r_op == OP_MUL) ? w_corrected[31:0] : w_corrected[63:32];
      end
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_mul_sequencer
//  Purpose  : Self-checking bench for dsp_mul_sequencer. Expected results are
//             computed from 64-bit sign/zero-extended operands, queued at
//             accept time and compared when out_valid is observed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  dsp_mul_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // One full transaction. hold = cycles to keep out_ready low once out_valid
  // is seen (0 means out_ready is already high when out_valid rises).
  // junk = toggle in_valid randomly while the block is busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit junk);
    int n;
    logic [31:0] exp, r0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(model(o, a, b));
    #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op = 2'($urandom);
    chk("busy_after_accept", busy, 1);
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 20) begin
      if (junk) in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 6);
    if (sb.size() > 0) exp = sb.pop_front();
    else begin exp = 32'hDEAD_BEEF; chk("sb_underflow", 1, 0); end
    chk("result", result, exp);
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, r0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1);
    chk("valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_result",    result,    0);

    run_op(2'b00, 32'd3, 32'd5, 1, 1'b0);                        // MUL 15
    chk("mul3x5_direct", model(2'b00, 32'd3, 32'd5), 32'h0000_000F);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);        // MULHU
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);        // MUL
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b1);        // MULH -1*-1
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);        // MULH
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);        // MULHSU
    run_op(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1'b1);       // backpressure
    for (int i = 0; i < 8; i++) begin
      run_op(2'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset sampled at E3 of an in-flight operation.
    op = 2'b11; op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D; in_valid = 1'b1;
    @(posedge clk); #1;                       // E0
    in_valid = 1'b0;
    @(posedge clk); #1;                       // E1
    @(posedge clk); #1;                       // E2
    reset = 1'b1;
    @(posedge clk); #1;                       // E3
    reset = 1'b0;
    chk("midrst_in_ready",  in_ready,  1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy",      busy,      0);
    chk("midrst_result",    result,    0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("midrst_no_valid", cnt, 0);
    run_op(2'b00, 32'd7, 32'd6, 0, 1'b0);                        // 42

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
